// File: rtl/imm_encoder.sv
// imm_encoder: packs RISC-V instruction fields plus a sign-extended immediate
// into a 32-bit instruction word, flags immediates that the chosen format
// cannot represent, and buffers results in a 2-entry output FIFO.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 (in_valid/in_ready on the request side, out_valid/out_ready on the
// result side). in_ready depends only on registered occupancy, never on
// out_ready, and out_valid/instr/err hold steady until the head is popped.
module imm_encoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    input  logic [2:0]           imm_src,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] SRC_I     = 3'b000;
    localparam logic [2:0] SRC_S     = 3'b001;
    localparam logic [2:0] SRC_B     = 3'b010;
    localparam logic [2:0] SRC_U     = 3'b011;
    localparam logic [2:0] SRC_J     = 3'b100;
    localparam logic [2:0] SRC_SHIFT = 3'b101;

    logic [31:0] enc_word;
    logic [31:0] enc_instr;
    logic        enc_err;

    logic [1:0]  occ;
    logic [31:0] head_instr;
    logic [31:0] tail_instr;
    logic        head_err;
    logic        tail_err;
    logic        push;
    logic        pop;

    // Pack the fields for the selected format and decide representability.
    always_comb begin
        enc_word = 32'h0000_0000;
        enc_err  = 1'b0;
        case (imm_src)
            SRC_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err  = (imm[31:11] != '0) && (imm[31:11] != '1);
            end
            SRC_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err  = (imm[31:11] != '0) && (imm[31:11] != '1);
            end
            SRC_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err  = ((imm[31:12] != '0) && (imm[31:12] != '1)) || imm[0];
            end
            SRC_U: begin
                enc_word = {imm[31:12], rd, opcode};
                enc_err  = (imm[11:0] != 12'h000);
            end
            SRC_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err  = ((imm[31:20] != '0) && (imm[31:20] != '1)) || imm[0];
            end
            SRC_SHIFT: begin
                enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                enc_err  = (imm[31:5] != '0);
            end
            default: begin
                enc_word = 32'h0000_0000;
                enc_err  = 1'b1;
            end
        endcase
        // Flagged entries never carry a partially packed word.
        enc_instr = enc_err ? 32'h0000_0000 : enc_word;
    end

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Two-slot buffer: head is the oldest entry, tail the younger one.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= 2'd0;
            head_instr <= 32'h0000_0000;
            head_err   <= 1'b0;
            tail_instr <= 32'h0000_0000;
            tail_err   <= 1'b0;
        end else begin
            if (pop) begin
                if (occ == 2'd2) begin
                    head_instr <= tail_instr;
                    head_err   <= tail_err;
                end else if (push) begin
                    head_instr <= enc_instr;
                    head_err   <= enc_err;
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    head_instr <= enc_instr;
                    head_err   <= enc_err;
                end else begin
                    tail_instr <= enc_instr;
                    tail_err   <= enc_err;
                end
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // Saturating count of accepted requests that were flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (push && enc_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign instr = out_valid ? head_instr : 32'h0000_0000;
    assign err   = out_valid ? head_err : 1'b0;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed spec vectors followed by randomized traffic,
// checked against a queue-based reference model of the encoder and buffer.
module tb_imm_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  imm_src;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [15:0] err_cnt;

    // Narrow-counter instance shares all inputs; only its counter is checked.
    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] instr2;
    logic        err2;
    logic [1:0]  err_cnt2;

    int n_checks;
    int n_fail;

    logic [32:0] exp_q[$];   // {instr, err}, oldest at front
    int          exp_cnt;
    int          exp_cnt2;

    imm_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .imm_src(imm_src), .out_valid(out_valid),
        .out_ready(out_ready), .instr(instr), .err(err), .err_cnt(err_cnt)
    );

    imm_encoder #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .imm_src(imm_src), .out_valid(out_valid2),
        .out_ready(out_ready), .instr(instr2), .err(err2), .err_cnt(err_cnt2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: representability from signed ranges, packing by bit arithmetic.
    function automatic logic [32:0] ref_enc();
        int          si;
        logic [31:0] u;
        logic [31:0] w;
        bit          ok;
        si = $signed(imm);
        u  = imm;
        w  = 0;
        ok = 0;
        case (imm_src)
            3'd0: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = ((u % 4096) << 20) | (32'(rs1) << 15) | (32'(funct3) << 12) | (32'(rd) << 7) | 32'(opcode);
            end
            3'd1: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = (((u >> 5) % 128) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(funct3) << 12)
                   | ((u % 32) << 7) | 32'(opcode);
            end
            3'd2: begin
                ok = (si >= -4096) && (si <= 4095) && (u % 2 == 0);
                w  = (((u >> 12) % 2) << 31) | (((u >> 5) % 64) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                   | (32'(funct3) << 12) | (((u >> 1) % 16) << 8) | (((u >> 11) % 2) << 7) | 32'(opcode);
            end
            3'd3: begin
                ok = (u % 4096 == 0);
                w  = u + (32'(rd) << 7) + 32'(opcode);
            end
            3'd4: begin
                ok = (si >= -(1 << 20)) && (si < (1 << 20)) && (u % 2 == 0);
                w  = (((u >> 20) % 2) << 31) | (((u >> 1) % 1024) << 21) | (((u >> 11) % 2) << 20)
                   | (((u >> 12) % 256) << 12) | (32'(rd) << 7) | 32'(opcode);
            end
            3'd5: begin
                ok = (u < 32);
                w  = (32'(funct7) << 25) | ((u % 32) << 20) | (32'(rs1) << 15) | (32'(funct3) << 12)
                   | (32'(rd) << 7) | 32'(opcode);
            end
            default: ok = 0;
        endcase
        if (!ok) w = 0;
        return {w, !ok};
    endfunction

    // One clock: model the edge with the current inputs, then check at negedge.
    task automatic tick();
        bit          acc;
        bit          pop;
        logic [32:0] e;
        acc = in_valid && (exp_q.size() < 2);
        pop = (exp_q.size() > 0) && out_ready;
        e   = ref_enc();
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_cnt  = 0;
            exp_cnt2 = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(e);
                if (e[0]) begin
                    if (exp_cnt < 65535) exp_cnt++;
                    if (exp_cnt2 < 3) exp_cnt2++;
                end
            end
        end
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("instr", 64'(instr), 64'(exp_q[0][32:1]));
            chk("err", 64'(err), 64'(exp_q[0][0]));
        end
        chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
        chk("err_cnt_w2", 64'(err_cnt2), 64'(exp_cnt2));
    endtask

    task automatic set_req(input logic v, input logic [2:0] src, input logic [6:0] op,
                           input logic [4:0] d, input logic [4:0] s1, input logic [31:0] im);
        in_valid = v;
        imm_src  = src;
        opcode   = op;
        rd       = d;
        rs1      = s1;
        rs2      = 5'd0;
        funct3   = 3'd0;
        funct7   = 7'd0;
        imm      = im;
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return 32'($urandom) << 12;
            3: return 32'($urandom_range(0, 40));
            4: return 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
            default: return 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
    endfunction

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_cnt   = 0;
        exp_cnt2  = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        set_req(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 32'd0);

        // Reset state
        @(negedge clk);
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        // I-type, one-cycle latency
        set_req(1'b1, 3'd0, 7'b0010011, 5'd1, 5'd0, 32'hFFFF_FFFF);
        tick();
        set_req(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 32'd0);
        chk("i_valid", 64'(out_valid), 64'd1);
        chk("i_instr", 64'(instr), 64'hFFF0_0093);
        chk("i_err", 64'(err), 64'd0);
        tick();

        // B-type: good and misaligned
        set_req(1'b1, 3'd2, 7'b1100011, 5'd0, 5'd0, 32'hFFFF_FFFC);
        tick();
        chk("b_instr", 64'(instr), 64'hFE00_0EE3);
        set_req(1'b1, 3'd2, 7'b1100011, 5'd0, 5'd0, 32'h0000_0003);
        tick();
        set_req(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 32'd0);
        chk("b_bad_err", 64'(err), 64'd1);
        chk("b_bad_instr", 64'(instr), 64'd0);
        chk("b_bad_cnt", 64'(err_cnt), 64'd1);
        tick();

        // U-type and J-type
        set_req(1'b1, 3'd3, 7'b0110111, 5'd5, 5'd0, 32'h1234_5000);
        tick();
        chk("u_instr", 64'(instr), 64'h1234_52B7);
        set_req(1'b1, 3'd4, 7'b1101111, 5'd1, 5'd0, 32'h0000_0800);
        tick();
        set_req(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 32'd0);
        chk("j_instr", 64'(instr), 64'h0010_00EF);
        tick();

        // Backpressure: three back-to-back requests with out_ready low
        out_ready = 1'b0;
        set_req(1'b1, 3'd0, 7'b0010011, 5'd2, 5'd3, 32'd10);
        tick();
        set_req(1'b1, 3'd0, 7'b0010011, 5'd4, 5'd5, 32'd20);
        tick();
        set_req(1'b1, 3'd0, 7'b0010011, 5'd6, 5'd7, 32'd30);
        tick();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("bp_hold_instr", 64'(instr), 64'h00A1_8113);
        out_ready = 1'b1;
        tick();
        tick();
        set_req(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 32'd0);
        tick();
        tick();

        // Reset with a full buffer and a request presented
        out_ready = 1'b0;
        set_req(1'b1, 3'd7, 7'd0, 5'd0, 5'd0, 32'd0);
        tick();
        tick();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 32'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cnt", 64'(err_cnt), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);

        // Saturation of the 2-bit counter: four errors -> 3
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 3'd5, 7'b0010011, 5'd1, 5'd1, 32'd32 + 32'(i));
            tick();
        end
        set_req(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 32'd0);
        tick();
        chk("sat_cnt_w2", 64'(err_cnt2), 64'd3);
        chk("sat_cnt_w16", 64'(err_cnt), 64'd4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            imm_src   = 3'($urandom_range(0, 7));
            opcode    = 7'($urandom);
            rd        = 5'($urandom);
            rs1       = 5'($urandom);
            rs2       = 5'($urandom);
            funct3    = 3'($urandom);
            funct7    = 7'($urandom);
            imm       = rand_imm();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
